// File: rtl/user_input_reader.sv
`default_nettype none
// ============================================================================
// Module   : user_input_reader
// Purpose  : Samples push-buttons / DIP switches. Each raw input is
//            synchronised, polarity-normalised (1 = pressed) and debounced
//            against a 1 ms tick. Debounced edges produce one-cycle
//            press/release pulses and are queued as events in a small FIFO
//            with a valid/ready read interface.
// Ports    : clk_i          system clock
//            rst_i          synchronous active-high reset
//            raw_i          asynchronous raw input levels
//            state_o        debounced state, 1 = pressed/on
//            press_o        1-cycle pulse when a state_o bit rises
//            release_o      1-cycle pulse when a state_o bit falls
//            evt_valid_o    event FIFO not empty
//            evt_ready_i    consumer pops the head on valid & ready
//            evt_data_o     head event {edge(1=press), index}, 0 when empty
//            evt_overflow_o sticky flag: an event was dropped
// Config   : UIR_FAST_SIM_EN - when defined, the tick period is 16 clocks
//            instead of CLK_IN_MHZ*1000 (simulation builds only).
// Revision : 1.0 - initial release
// ============================================================================
module user_input_reader #(
    parameter int   CLK_IN_MHZ     = 100,
    parameter int   NUM_INPUTS     = 8,
    parameter int   DEBOUNCE_MS    = 10,
    parameter logic INPUT_POLARITY = 1'b0,
    parameter int   FIFO_DEPTH     = 4,
    localparam int  c_IW           = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_INPUTS-1:0] raw_i,
    output logic [NUM_INPUTS-1:0] state_o,
    output logic [NUM_INPUTS-1:0] press_o,
    output logic [NUM_INPUTS-1:0] release_o,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [c_IW:0]         evt_data_o,
    output logic                  evt_overflow_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
`ifdef UIR_FAST_SIM_EN
    localparam int c_TICK_PERIOD = 16;
`else
    localparam int c_TICK_PERIOD = CLK_IN_MHZ * 1000;
`endif
    localparam int c_PRESC_W = (c_TICK_PERIOD > 1) ? $clog2(c_TICK_PERIOD) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(c_TICK_PERIOD - 1);

    localparam int c_CNT_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_MS - 1);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Two-flop synchroniser and polarity normalisation
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] r_sync1;
    logic [NUM_INPUTS-1:0] r_sync2;
    logic [NUM_INPUTS-1:0] w_norm;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_i;
            r_sync2 <= r_sync1;
        end
    end

    // XOR with the inverted "pressed" level makes a pressed input read as 1.
    assign w_norm = r_sync2 ^ {NUM_INPUTS{~INPUT_POLARITY}};

    // ------------------------------------------------------------------
    // 1 ms tick prescaler
    // ------------------------------------------------------------------
    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_tick;

    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-input debounce: count ticks while the normalised level disagrees
    // with the debounced state; any agreement restarts the count.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_state;
        logic               r_press;
        logic               r_release;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_cnt     <= '0;
                r_state   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (w_norm[gi] == r_state) begin
                    r_cnt <= '0;
                end else if (w_tick) begin
                    if (r_cnt == c_CNT_LAST) begin
                        // Pulses are registered together with the state flip
                        // so they line up with the visible state_o change.
                        r_cnt     <= '0;
                        r_state   <= ~r_state;
                        r_press   <= ~r_state;
                        r_release <= r_state;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end
        end

        assign state_o[gi]   = r_state;
        assign press_o[gi]   = r_press;
        assign release_o[gi] = r_release;
    end

    // ------------------------------------------------------------------
    // Event arbitration: one pending bit per input, lowest index served
    // first, one event moved towards the FIFO per cycle.
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] r_pending;
    logic [NUM_INPUTS-1:0] r_pend_edge;
    logic [NUM_INPUTS-1:0] w_edges;
    logic [NUM_INPUTS-1:0] w_grant;
    logic [c_IW-1:0]       w_grant_idx;
    logic                  w_any_pending;
    logic                  w_collide;

    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        // Descending scan: the last hit (lowest index) wins.
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_grant     = '0;
                w_grant[i]  = 1'b1;
                w_grant_idx = c_IW'(i);
            end
        end
    end

    assign w_edges       = press_o | release_o;
    assign w_any_pending = |r_pending;
    // A new edge on an input whose previous edge is still waiting (and is
    // not being served this cycle) loses the older edge.
    assign w_collide     = |(r_pending & ~w_grant & w_edges);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending   <= '0;
            r_pend_edge <= '0;
        end else begin
            r_pending   <= (r_pending & ~w_grant) | w_edges;
            r_pend_edge <= (r_pend_edge & ~w_edges) | (press_o & w_edges);
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [c_IW:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;
    logic             w_drop;
    logic [c_IW:0]    w_wr_data;

    // Fullness is judged before any same-cycle pop, so a full FIFO drops.
    assign w_full      = (r_count == c_FULL_CNT);
    assign w_wr        = w_any_pending & ~w_full;
    assign w_drop      = w_any_pending & w_full;
    assign w_rd        = evt_valid_o & evt_ready_i;
    assign w_wr_data   = {r_pend_edge[w_grant_idx], w_grant_idx};
    assign evt_valid_o = (r_count != '0);
    assign evt_data_o  = evt_valid_o ? r_mem[r_rd_ptr] : '0;

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------
    logic r_overflow;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop || w_collide) begin
            r_overflow <= 1'b1;
        end
    end

    assign evt_overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_user_input_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_user_input_reader
// Purpose  : Self-checking bench for user_input_reader (8 active-low inputs,
//            2 ms debounce, 4-entry FIFO). Directed table and hand-written
//            sequences, then randomized stimulus; a behavioural model checks
//            every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_user_input_reader;

    localparam int   c_NI      = 8;
    localparam int   c_DEB     = 2;
    localparam int   c_DEPTH   = 4;
    localparam logic c_POL     = 1'b0;
    localparam int   c_CLK_MHZ = 1;
`ifdef UIR_FAST_SIM_EN
    localparam int   c_P       = 16;
`else
    localparam int   c_P       = c_CLK_MHZ * 1000;
`endif
    localparam int   c_SETTLE  = 2 + c_DEB * c_P + 16;
    localparam int   c_LAT_LO  = (c_DEB - 1) * c_P + 3;
    localparam int   c_LAT_HI  = c_DEB * c_P + 2;
    localparam int   c_RAND_CYCLES = 12 * c_DEB * c_P + 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw;
    logic       ready;
    logic [7:0] state_o, press_o, release_o;
    logic       evt_valid_o, evt_overflow_o;
    logic [3:0] evt_data_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    user_input_reader #(
        .CLK_IN_MHZ    (c_CLK_MHZ),
        .NUM_INPUTS    (c_NI),
        .DEBOUNCE_MS   (c_DEB),
        .INPUT_POLARITY(c_POL),
        .FIFO_DEPTH    (c_DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .raw_i         (raw),
        .state_o       (state_o),
        .press_o       (press_o),
        .release_o     (release_o),
        .evt_valid_o   (evt_valid_o),
        .evt_ready_i   (ready),
        .evt_data_o    (evt_data_o),
        .evt_overflow_o(evt_overflow_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the debounced state flips on the DEB-th tick seen
    // while the synchronised level keeps disagreeing with it; events go
    // through a pending set and a bounded queue.
    // ------------------------------------------------------------------
    bit         m_armed = 1'b0;
    int         m_cyc;
    logic [7:0] m_s1, m_s2, m_state, m_press, m_rel, m_pend, m_ptype;
    int         m_ticks [c_NI];
    logic [3:0] m_q [$];
    logic       m_ovf;

    always @(posedge clk) begin : p_model
        int         g;
        bit         tick, full_old, rd;
        logic [7:0] nrm, edg;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_press = '0; m_rel = '0;
            m_pend = '0; m_ptype = '0; m_ovf = 1'b0; m_cyc = 0;
            foreach (m_ticks[i]) m_ticks[i] = 0;
            m_q.delete();
            m_armed = 1'b1;
        end else begin
            edg      = m_press | m_rel;
            full_old = (m_q.size() == c_DEPTH);
            rd       = (m_q.size() != 0) && ready;
            g = -1;
            for (int i = c_NI - 1; i >= 0; i--) if (m_pend[i]) g = i;
            if (rd) void'(m_q.pop_front());
            if (g >= 0) begin
                if (full_old) m_ovf = 1'b1;
                else m_q.push_back({m_ptype[g], 3'(g)});
                m_pend[g] = 1'b0;
            end
            for (int i = 0; i < c_NI; i++) begin
                if (edg[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    m_pend[i]  = 1'b1;
                    m_ptype[i] = m_press[i];
                end
            end
            nrm  = m_s2 ^ {c_NI{~c_POL}};
            tick = ((m_cyc % c_P) == c_P - 1);
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < c_NI; i++) begin
                if (nrm[i] == m_state[i]) m_ticks[i] = 0;
                else if (tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == c_DEB) begin
                        m_ticks[i] = 0;
                        m_state[i] = ~m_state[i];
                        if (m_state[i]) m_press[i] = 1'b1;
                        else m_rel[i] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            check("model",
                  {2'b0, state_o, press_o, release_o, evt_valid_o, evt_data_o, evt_overflow_o},
                  {2'b0, m_state, m_press, m_rel, (m_q.size() != 0),
                   ((m_q.size() != 0) ? m_q[0] : 4'h0), m_ovf});
        end
    end

    task automatic pop_expect(input string name, input logic [3:0] exp);
        check(name, {27'd0, evt_valid_o, evt_data_o}, {27'd0, 1'b1, exp});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  raw;
        logic [7:0]  exp_state;
        int          n_ev;
        logic [15:0] evs;       // event k in evs[4k +: 4]
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int         lat;
        logic [7:0] seen;
        logic [7:0] flip;
        int         cyc, dur;

        tbl[0] = '{8'hBF, 8'h40, 1, 16'h000E, 1'b0};
        tbl[1] = '{8'hFF, 8'h00, 1, 16'h0006, 1'b0};
        tbl[2] = '{8'hDD, 8'h22, 2, 16'h00D9, 1'b0};
        tbl[3] = '{8'hFF, 8'h00, 2, 16'h0051, 1'b0};
        tbl[4] = '{8'h0F, 8'hF0, 4, 16'hFEDC, 1'b0};
        tbl[5] = '{8'hFF, 8'h00, 4, 16'h7654, 1'b0};
        tbl[6] = '{8'hE0, 8'h1F, 4, 16'hBA98, 1'b1};
        tbl[7] = '{8'hFF, 8'h00, 4, 16'h3210, 1'b1};

        // Reset with all buttons released
        rst = 1'b1; raw = 8'hFF; ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {state_o, press_o, release_o, evt_valid_o, evt_data_o, evt_overflow_o}, 32'd0);
        rst = 1'b0;
        seen = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            seen |= state_o | press_o | release_o
                  | {7'd0, evt_valid_o} | {4'd0, evt_data_o} | {7'd0, evt_overflow_o};
        end
        check("idle_after_reset", {24'd0, seen}, 32'd0);

        // Clean press on input 3: latency, pulse width, FIFO write latency
        raw = 8'hF7;
        lat = 0;
        while (lat < c_LAT_HI + 4 && !state_o[3]) begin
            @(negedge clk);
            lat++;
        end
        n_total++;
        if (state_o[3] && lat >= c_LAT_LO && lat <= c_LAT_HI) n_pass++;
        else $display("FAIL press_latency: got %0d cycles (state %0b), expected %0d..%0d",
                      lat, state_o[3], c_LAT_LO, c_LAT_HI);
        check("press_pulse_on", {24'd0, press_o}, 32'h08);
        @(negedge clk);
        check("press_pulse_off", {24'd0, press_o}, 32'h00);
        check("valid_before_write", {31'd0, evt_valid_o}, 32'd0);
        @(negedge clk);
        pop_expect("press3_event", 4'hB);
        check("empty_after_pop", {31'd0, evt_valid_o}, 32'd0);
        raw = 8'hFF;
        repeat (c_SETTLE) @(negedge clk);
        check("release3_state", {24'd0, state_o}, 32'h00);
        pop_expect("release3_event", 4'h3);

        // Glitch on input 0 shorter than one tick
        raw = 8'hFE;
        seen = '0;
        repeat (10) begin @(negedge clk); seen |= press_o | state_o; end
        raw = 8'hFF;
        repeat (c_SETTLE) begin @(negedge clk); seen |= press_o | state_o; end
        check("glitch_no_change", {24'd0, seen}, 32'd0);
        check("glitch_no_event", {31'd0, evt_valid_o}, 32'd0);

        // Table: press patterns, ordered event lists, overflow
        for (int i = 0; i < 8; i++) begin
            raw = tbl[i].raw;
            repeat (c_SETTLE) @(negedge clk);
            check($sformatf("tbl%0d_state", i), {24'd0, state_o}, {24'd0, tbl[i].exp_state});
            check($sformatf("tbl%0d_ovf", i), {31'd0, evt_overflow_o}, {31'd0, tbl[i].exp_ovf});
            for (int k = 0; k < tbl[i].n_ev; k++)
                pop_expect($sformatf("tbl%0d_ev%0d", i, k), tbl[i].evs[4*k +: 4]);
            check($sformatf("tbl%0d_drained", i), {31'd0, evt_valid_o}, 32'd0);
        end
        check("ovf_sticky", {31'd0, evt_overflow_o}, 32'd1);

        // Mid-operation reset: two events queued, input 3 mid-count
        raw = 8'hDD;
        repeat (c_SETTLE) @(negedge clk);
        raw = 8'hD5;
        repeat (c_P + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cleared",
              {state_o, press_o, release_o, evt_valid_o, evt_data_o, evt_overflow_o}, 32'd0);
        repeat (c_SETTLE) @(negedge clk);
        check("held_through_reset_state", {24'd0, state_o}, 32'h2A);
        pop_expect("held_ev0", 4'h9);
        pop_expect("held_ev1", 4'hB);
        pop_expect("held_ev2", 4'hD);
        check("held_drained", {31'd0, evt_valid_o}, 32'd0);

        // Randomized phase, checked by the model each cycle
        cyc = 0;
        while (cyc < c_RAND_CYCLES) begin
            flip = 8'($urandom);
            if ($urandom_range(0, 1) == 1) flip &= 8'($urandom);
            raw ^= flip;
            if ($urandom_range(0, 3) == 0) dur = $urandom_range(1, c_P / 2);
            else dur = $urandom_range(c_P, 3 * c_DEB * c_P);
            if ($urandom_range(0, 29) == 0) rst = 1'b1;
            for (int d = 0; d < dur; d++) begin
                ready = ($urandom_range(0, 2) == 0);
                @(negedge clk);
                rst = 1'b0;
                cyc++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
